// File: rtl/ascii_tx_scheduler_if.sv
// Request/transmit bundle between two requesters, the scheduler and a byte transmitter.
// The master modport is the scheduler's view.
interface ascii_tx_scheduler_if;
  logic        req0_ready;
  logic [15:0] req0_data;
  logic        req0_done;
  logic        req1_ready;
  logic [15:0] req1_data;
  logic        req1_done;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_done;
  logic        busy;
  logic        timeout_err;

  modport master (
    input  req0_ready, req0_data, req1_ready, req1_data, tx_done,
    output req0_done, req1_done, tx_byte, tx_start, busy, timeout_err
  );

  modport slave (
    output req0_ready, req0_data, req1_ready, req1_data, tx_done,
    input  req0_done, req1_done, tx_byte, tx_start, busy, timeout_err
  );
endinterface

// File: rtl/ascii_tx_scheduler.sv
// Round-robin scheduler turning 16-bit words from two channels into ASCII hex frames
// ("T"/"I" tag, four hex digits, optional CR LF), one byte at a time.
module ascii_tx_scheduler #(
  parameter bit          APPEND_CRLF    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic                       clk_i,
  input logic                       rst_ni,
  ascii_tx_scheduler_if.master      sched_io
);

  typedef enum logic [1:0] {StIdle, StSend, StWait, StAck} state_e;

  localparam logic [2:0]  LastIdx = APPEND_CRLF ? 3'd6 : 3'd4;
  localparam logic [23:0] CntMax  = 24'(TIMEOUT_CYCLES - 1);

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic chan,
                                            input logic [15:0] data);
    case (idx)
      3'd0:    return chan ? 8'h49 : 8'h54;
      3'd1:    return hex_char(data[15:12]);
      3'd2:    return hex_char(data[11:8]);
      3'd3:    return hex_char(data[7:4]);
      3'd4:    return hex_char(data[3:0]);
      3'd5:    return 8'h0D;
      3'd6:    return 8'h0A;
      default: return 8'h00;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [15:0] data_q, data_d;
  logic        chan_q, chan_d;
  logic        last_q, last_d;
  logic [2:0]  idx_q, idx_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        tx_start_q, tx_start_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    chan_d     = chan_q;
    last_d     = last_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    tx_byte_d  = tx_byte_q;
    tx_start_d = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (sched_io.req0_ready || sched_io.req1_ready) begin
          // ch1 wins only when alone or when ch0 was served last
          chan_d     = sched_io.req1_ready && (!sched_io.req0_ready || !last_q);
          data_d     = chan_d ? sched_io.req1_data : sched_io.req0_data;
          idx_d      = 3'd0;
          tx_start_d = 1'b1;
          state_d    = StSend;
        end
      end
      StSend: begin
        cnt_d   = 24'd0;
        state_d = StWait;
      end
      StWait: begin
        if (sched_io.tx_done) begin
          if (idx_q == LastIdx) begin
            state_d = StAck;
            done0_d = !chan_q;
            done1_d = chan_q;
          end else begin
            idx_d      = idx_q + 3'd1;
            tx_start_d = 1'b1;
            state_d    = StSend;
          end
        end else if (cnt_q == CntMax) begin
          err_d   = 1'b1;
          state_d = StAck;
          done0_d = !chan_q;
          done1_d = chan_q;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      StAck: begin
        last_d  = chan_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so the byte for the next SEND is chosen here.
    if (tx_start_d) tx_byte_d = frame_byte(idx_d, chan_d, data_d);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      data_q     <= 16'h0000;
      chan_q     <= 1'b0;
      last_q     <= 1'b1;
      idx_q      <= 3'd0;
      cnt_q      <= 24'd0;
      tx_byte_q  <= 8'h00;
      tx_start_q <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      chan_q     <= chan_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      tx_byte_q  <= tx_byte_d;
      tx_start_q <= tx_start_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign sched_io.tx_byte     = tx_byte_q;
  assign sched_io.tx_start    = tx_start_q;
  assign sched_io.req0_done   = done0_q;
  assign sched_io.req1_done   = done1_q;
  assign sched_io.busy        = busy_q;
  assign sched_io.timeout_err = err_q;

endmodule

// File: tb/tb_ascii_tx_scheduler.sv
// Bench for ascii_tx_scheduler: a transmitter model with a byte/done scoreboard on the CRLF
// instance, table-driven frames, and hand sequences for timeout, reset, arbitration and no-CRLF.
module tb_ascii_tx_scheduler;

  typedef struct {
    bit              ch;
    logic [15:0]     data;
    bit              drop_early;
    bit              coincide;
    logic [0:6][7:0] b;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ascii_tx_scheduler_if ifa ();
  ascii_tx_scheduler_if ifb ();

  ascii_tx_scheduler #(.APPEND_CRLF(1'b1), .TIMEOUT_CYCLES(16)) u_dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .sched_io(ifa)
  );

  ascii_tx_scheduler #(.APPEND_CRLF(1'b0), .TIMEOUT_CYCLES(16)) u_dut_nocrlf (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .sched_io(ifb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  bit         done_q[$];
  bit         tx_en    = 1'b1;
  bit         coincide = 1'b0;
  bit         stray    = 1'b0;
  int         tx_delay = 3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit ch, input logic rdy, input logic [15:0] d);
    if (ch) begin
      ifa.req1_ready = rdy;
      ifa.req1_data  = d;
    end else begin
      ifa.req0_ready = rdy;
      ifa.req0_data  = d;
    end
  endtask

  // Transmitter model and scoreboard for the CRLF instance.
  initial begin
    int  pend;
    bit  ch;
    pend = 0;
    ifa.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      ifa.tx_done = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else if (ifa.tx_start) begin
        check("start_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("tx_byte", 32'(ifa.tx_byte), 32'(exp_q.pop_front()));
        if (tx_en) pend = tx_delay;
        if (coincide) ifa.tx_done = 1'b1;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) ifa.tx_done = 1'b1;
      end
      if (stray) begin
        ifa.tx_done = 1'b1;
        stray = 1'b0;
      end
      if (ifa.req0_done || ifa.req1_done) begin
        check("done_expected", 32'(done_q.size() != 0), 32'd1);
        if (done_q.size() != 0) begin
          ch = done_q.pop_front();
          check("done_ch0", 32'(ifa.req0_done), 32'(!ch));
          check("done_ch1", 32'(ifa.req1_done), 32'(ch));
        end
      end
    end
  end

  task automatic run_frame(input vec_t v, input string tag);
    bit got     = 1'b0;
    bit started = 1'b0;
    int t_start = 0;
    int lat     = -1;
    for (int i = 0; i < 7; i++) exp_q.push_back(v.b[i]);
    done_q.push_back(v.ch);
    stray    = 1'b1;
    coincide = v.coincide;
    repeat (3) @(negedge clk);
    set_req(v.ch, 1'b1, v.data);
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (!started && ifa.tx_start) begin
        started = 1'b1;
        t_start = c;
        lat     = c;
        check({tag, "_busy"}, 32'(ifa.busy), 32'd1);
        set_req(v.ch, !v.drop_early, ~v.data);
      end
      if (v.ch ? ifa.req1_done : ifa.req0_done) begin
        got = 1'b1;
        set_req(v.ch, 1'b0, ~v.data);
        check({tag, "_frame_cycles"}, 32'(c - t_start), 32'd28);
      end
    end
    coincide = 1'b0;
    set_req(v.ch, 1'b0, v.data);
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_grant_latency"}, 32'(lat), 32'd0);
    @(negedge clk);
    check({tag, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle_busy"}, 32'(ifa.busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t            vecs[6];
    vec_t            vr;
    logic [0:4][7:0] nocrlf_exp;
    bit              got;
    int              cnt;
    int              nb;
    int              pend_b;

    vecs[0] = '{1'b0, 16'h9CB5, 1'b0, 1'b0, 56'h54_39_43_42_35_0D_0A};
    vecs[1] = '{1'b1, 16'h0000, 1'b0, 1'b0, 56'h49_30_30_30_30_0D_0A};
    vecs[2] = '{1'b1, 16'hFFFF, 1'b1, 1'b0, 56'h49_46_46_46_46_0D_0A};
    vecs[3] = '{1'b0, 16'h1A2F, 1'b0, 1'b1, 56'h54_31_41_32_46_0D_0A};
    vecs[4] = '{1'b0, 16'h7E08, 1'b0, 1'b0, 56'h54_37_45_30_38_0D_0A};
    vecs[5] = '{1'b1, 16'hA5C3, 1'b1, 1'b1, 56'h49_41_35_43_33_0D_0A};
    vr      = '{1'b1, 16'h4D2C, 1'b0, 1'b0, 56'h49_34_44_32_43_0D_0A};
    nocrlf_exp = 40'h54_31_41_32_46;

    rst_n = 1'b0;
    ifa.req0_ready = 1'b0; ifa.req0_data = 16'h0; ifa.req1_ready = 1'b0; ifa.req1_data = 16'h0;
    ifb.req0_ready = 1'b0; ifb.req0_data = 16'h0; ifb.req1_ready = 1'b0; ifb.req1_data = 16'h0;
    ifb.tx_done = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_tx_byte", 32'(ifa.tx_byte), 32'h00);
    check("rst_tx_start", 32'(ifa.tx_start), 32'd0);
    check("rst_busy", 32'(ifa.busy), 32'd0);
    check("rst_err", 32'(ifa.timeout_err), 32'd0);
    check("rst_done", 32'({ifa.req0_done, ifa.req1_done}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(ifa.busy), 32'd0);

    foreach (vecs[i]) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Transmitter silent: abort after 16 WAIT cycles.
    tx_en = 1'b0;
    exp_q.push_back(8'h54);
    done_q.push_back(1'b0);
    set_req(1'b0, 1'b1, 16'h0123);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = ifa.tx_start;
    end
    check("to_start_seen", 32'(got), 32'd1);
    check("to_err_before", 32'(ifa.timeout_err), 32'd0);
    got = 1'b0;
    cnt = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      cnt++;
      if (ifa.req0_done) begin
        got = 1'b1;
        set_req(1'b0, 1'b0, 16'h0123);
        check("to_err_at_done", 32'(ifa.timeout_err), 32'd1);
      end
    end
    check("to_done_seen", 32'(got), 32'd1);
    check("to_cycles", 32'(cnt), 32'd17);
    repeat (5) @(negedge clk);
    check("to_err_sticky", 32'(ifa.timeout_err), 32'd1);
    check("to_idle", 32'(ifa.busy), 32'd0);
    check("to_bytes_left", 32'(exp_q.size()), 32'd0);
    tx_en = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check("to_err_cleared", 32'(ifa.timeout_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while waiting on the third byte.
    for (int i = 0; i < 7; i++) exp_q.push_back(8'(56'h54_33_42_37_44_0D_0A >> (8 * (6 - i))));
    done_q.push_back(1'b0);
    set_req(1'b0, 1'b1, 16'h3B7D);
    nb = 0;
    for (int c = 0; c < 100 && nb < 3; c++) begin
      @(negedge clk);
      if (ifa.tx_start) nb++;
    end
    check("mr_third_start", 32'(nb), 32'd3);
    @(negedge clk);
    check("mr_busy_before", 32'(ifa.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_tx_byte", 32'(ifa.tx_byte), 32'h00);
    check("mr_tx_start", 32'(ifa.tx_start), 32'd0);
    check("mr_busy", 32'(ifa.busy), 32'd0);
    check("mr_done", 32'({ifa.req0_done, ifa.req1_done}), 32'd0);
    exp_q.delete();
    done_q.delete();
    set_req(1'b0, 1'b0, 16'h3B7D);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    run_frame(vr, "post_rst");

    // Both channels held: strict alternation starting with ch0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 7; i++) begin
        if (f == 1) exp_q.push_back(8'(56'h49_46_46_46_46_0D_0A >> (8 * (6 - i))));
        else        exp_q.push_back(8'(56'h54_30_30_30_30_0D_0A >> (8 * (6 - i))));
      end
      done_q.push_back(f == 1);
    end
    set_req(1'b0, 1'b1, 16'h0000);
    set_req(1'b1, 1'b1, 16'hFFFF);
    nb = 0;
    for (int c = 0; c < 400 && nb < 3; c++) begin
      @(negedge clk);
      if (ifa.req0_done || ifa.req1_done) nb++;
      if (nb == 3) begin
        set_req(1'b0, 1'b0, 16'h0000);
        set_req(1'b1, 1'b0, 16'hFFFF);
      end
    end
    set_req(1'b0, 1'b0, 16'h0000);
    set_req(1'b1, 1'b0, 16'hFFFF);
    check("rr_frames", 32'(nb), 32'd3);
    repeat (3) @(negedge clk);
    check("rr_bytes_left", 32'(exp_q.size()), 32'd0);
    check("rr_dones_left", 32'(done_q.size()), 32'd0);
    check("rr_idle", 32'(ifa.busy), 32'd0);

    // No-CRLF instance: five bytes, then Done.
    ifb.req0_data  = 16'h1A2F;
    ifb.req0_ready = 1'b1;
    nb     = 0;
    pend_b = 0;
    got    = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      ifb.tx_done = 1'b0;
      if (ifb.tx_start) begin
        if (nb < 5) check($sformatf("nocrlf_byte%0d", nb), 32'(ifb.tx_byte), 32'(nocrlf_exp[nb]));
        nb++;
        pend_b = 2;
      end else if (pend_b > 0) begin
        pend_b--;
        if (pend_b == 0) ifb.tx_done = 1'b1;
      end
      if (ifb.req0_done) begin
        got = 1'b1;
        ifb.req0_ready = 1'b0;
        check("nocrlf_done1", 32'(ifb.req1_done), 32'd0);
      end
    end
    ifb.req0_ready = 1'b0;
    ifb.tx_done    = 1'b0;
    check("nocrlf_done", 32'(got), 32'd1);
    check("nocrlf_nbytes", 32'(nb), 32'd5);
    repeat (2) @(negedge clk);
    check("nocrlf_idle", 32'(ifb.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
